syzygy_adc_capture_buf: RTL and testbench
=========================================

Name: syzygy_adc_capture_buf

Overview:
- Capture-side counterpart of the DAC playback buffer in the FFT sample design.
- Accepts a stream of 12-bit ADC samples in offset-binary format and converts each sample to two's complement.
- Stores one frame of 2^ADDR_W samples in a dual-port RAM, started by an arm command with an optional trigger.
- Once the frame is complete, host or FFT logic reads it back by address.

Parameters:
- DATA_W, 12: sample width, in bits.
- ADDR_W, 8: buffer address width. Frame length is 2^ADDR_W = 256 samples.

Ports:
- clk, input, 1: single clock. ADC and read side both run on this clock.
- reset, input, 1: asynchronous, active-high reset. Deassertion is synchronised externally.
- arm, input, 1: single-cycle pulse that starts a capture.
- trig_mode, input, 1: 0 = capture starts immediately on arm; 1 = capture waits for trig. Sampled on the arm cycle.
- trig, input, 1: external trigger, level-sampled.
- abort, input, 1: cancels a capture in progress.
- data_valid, input, 1: qualifies data_i.
- data_i, input, DATA_W: ADC sample, offset binary.
- rd_en, input, 1: read enable.
- rd_addr, input, ADDR_W: read address.
- data_o, output, DATA_W: read data, two's complement, registered.
- busy, output, 1: high in WAIT_TRIG or CAPTURE.
- done, output, 1: frame complete. Sticky until the next accepted arm or reset.
- sample_count, output, ADDR_W+1: number of samples written in the current or most recent capture.

Behaviour:
- Reset (asynchronous):
  - state = IDLE, write address = 0.
  - sample_count = 0, busy = 0, done = 0, data_o = 0.
  - RAM contents are not cleared.
- Conversion: stored word = {~data_i[DATA_W-1], data_i[DATA_W-2:0]}. The MSB is inverted, so 0x800 stores as 0x000 and 0x000 stores as 0x800. No saturation.
- State machine, one-hot or encoded: IDLE, WAIT_TRIG, CAPTURE, DONE.
  - IDLE or DONE, arm=1:
    - Clear done, sample_count and write address.
    - Go to CAPTURE if trig_mode=0, otherwise WAIT_TRIG.
    - busy rises the following cycle.
  - WAIT_TRIG, trig=1: go to CAPTURE. Samples are accepted from the next cycle onward; the sample on the trigger cycle is not stored.
  - CAPTURE, data_valid=1:
    - Write the converted sample at the write address, then increment the address and sample_count.
    - On the write that makes sample_count = 2^ADDR_W, go to DONE: done=1 and busy=0 from the next cycle.
  - CAPTURE, data_valid=0: hold; no write.
  - DONE: hold until arm.
- Write address wraps 255 -> 0 but never writes past a full frame. Exactly 256 writes per capture.
- arm while busy is ignored. State and counters are unchanged.
- abort:
  - In WAIT_TRIG or CAPTURE: go to IDLE on the next cycle. done stays 0 and sample_count holds its partial value.
  - In IDLE or DONE: no effect.
- Priority: abort > arm > trig/data_valid. If abort and the final write coincide, the final write completes, but the state goes to IDLE and done stays 0.
- Read port:
  - rd_en=1: data_o = RAM[rd_addr] on the next clock edge (1-cycle latency).
  - rd_en=0: data_o holds its value.
  - Reads are legal in every state.
  - A read and write to the same address in the same cycle returns the old data (read-first).
- busy and done are registered outputs and are never high together.

Decomposition:
- Package syzygy_adc_pkg:
  - DATA_W and ADDR_W defaults.
  - FRAME_LEN = 2^ADDR_W.
  - State encoding localparams.
  - Offset-binary to two's-complement conversion function.
- Sub-module syzygy_adc_capture_ram:
  - Inferred simple dual-port RAM, one write port and one read port, read-first, synchronous read, no reset on the array. No vendor IP.
- Top level contains the FSM, counters and conversion only.

Test Plan:
- Immediate mode: reset, then pulse arm with trig_mode=0, then drive 256 valid samples data_i = 0x800+n (n = 0..255) -> done=1 one cycle after the last write, sample_count = 256, and reading address n returns n (address 0 returns 0x000, address 255 returns 0x0FF) with 1-cycle latency.
- Conversion extremes: capture the pattern 0x000, 0xFFF, 0x800, 0x7FF -> reads return 0x800, 0x7FF, 0x000, 0xFFF.
- Trigger mode with data_valid gaps:
  - Arm with trig_mode=1, drive valid samples for 20 cycles before trig -> nothing written, sample_count = 0, busy=1.
  - Pulse trig, then toggle data_valid 1/0 -> only the valid samples are stored, and exactly 256 are stored.
- Abort and re-arm:
  - Abort after 100 samples -> IDLE next cycle, busy=0, done=0, sample_count = 100.
  - A second arm mid-capture is ignored.
  - A subsequent arm captures a full frame.
- Reset mid-capture: assert reset asynchronously (between clock edges) after 50 samples -> all outputs go to their reset values without waiting for a clock edge. After release, an arm/capture cycle completes normally.
- Read during capture:
  - Read address k in the same cycle it is written -> returns the previous-frame value.
  - Read it again on the next cycle -> returns the new value.

Source files
------------

// File: rtl/syzygy_adc_pkg.sv
// Shared definitions for the ADC capture buffer: default sizes, FSM states and
// the offset-binary to two's-complement sample conversion.
package syzygy_adc_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 8;
  localparam int FRAME_LEN  = 1 << ADDR_W_DEF;

  // Wide enough for any sample width this block is built with.
  localparam int CONV_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // Offset binary and two's complement differ only in the sign bit.
  function automatic logic [CONV_W-1:0] offset_to_twos(input logic [CONV_W-1:0] sample,
                                                       input int width);
    return sample ^ (CONV_W'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/syzygy_adc_capture_ram.sv
// Simple dual-port frame RAM: one write port, one registered read-first port.
module syzygy_adc_capture_ram
  import syzygy_adc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: non-blocking updates make a same-cycle read see the old word (read-first).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/syzygy_adc_capture_buf.sv
// ADC frame capture: arm/trigger FSM, sample counter and sign conversion in
// front of a dual-port frame RAM that the host reads back by address.
module syzygy_adc_capture_buf
  import syzygy_adc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              trig_mode,
  input  logic              trig,
  input  logic              abort,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_o,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              busy_q, done_q;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  assign wr_data = DATA_W'(offset_to_twos(CONV_W'(data_i), DATA_W));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          count_d = '0;
          state_d = trig_mode ? ST_WAIT_TRIG : ST_CAPTURE;
        end
      end
      ST_WAIT_TRIG: begin
        if (abort)     state_d = ST_IDLE;
        else if (trig) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (data_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + COUNT_ONE;
          if (count_d == FULL_COUNT) state_d = ST_DONE;
        end
        // An in-flight write still lands, but abort wins over completion.
        if (abort) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= (state_d == ST_WAIT_TRIG) || (state_d == ST_CAPTURE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = count_q;

  // The write address is the low bits of the count, so it wraps 255 -> 0 for free.
  syzygy_adc_capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (count_q[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (data_o)
  );

endmodule

// File: tb/tb_syzygy_adc_capture_buf.sv
// Directed bench for the ADC capture buffer: capture modes, conversion,
// abort, asynchronous reset and read-first behaviour.
module tb_syzygy_adc_capture_buf;
  import syzygy_adc_pkg::*;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        trig_mode;
  logic        trig;
  logic        abort;
  logic        data_valid;
  logic [11:0] data_i;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [11:0] data_o;
  logic        busy;
  logic        done;
  logic [8:0]  sample_count;

  int n_cmp = 0;
  int n_err = 0;

  syzygy_adc_capture_buf dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .trig_mode    (trig_mode),
    .trig         (trig),
    .abort        (abort),
    .data_valid   (data_valid),
    .data_i       (data_i),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .data_o       (data_o),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic mode);
    trig_mode = mode;
    arm       = 1'b1;
    cyc();
    arm       = 1'b0;
  endtask

  // Drives n consecutive valid samples raw_base+k for k = start .. start+n-1.
  task automatic feed(input logic [11:0] raw_base, input int n, input int start);
    for (int k = start; k < start + n; k++) begin
      data_valid = 1'b1;
      data_i     = raw_base + 12'(k);
      cyc();
    end
    data_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr);
    rd_en   = 1'b1;
    rd_addr = addr;
    cyc();
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (sample_count !== 9'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", sample_count); end
    n_cmp++; if (data_o !== 12'h000) begin n_err++; $display("FAIL reset_data: got %h want 000", data_o); end
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL idle_flags: got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_immediate();
    do_arm(1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL imm_busy_rise: got %b want 1", busy); end
    feed(12'h800, FRAME_LEN - 1, 0);
    n_cmp++; if (sample_count !== 9'd255 || done !== 1'b0) begin n_err++; $display("FAIL imm_pre_last: got count=%0d done=%b want 255/0", sample_count, done); end
    feed(12'h800, 1, FRAME_LEN - 1);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL imm_done: got done=%b busy=%b want 1/0", done, busy); end
    n_cmp++; if (sample_count !== 9'd256) begin n_err++; $display("FAIL imm_count: got %0d want 256", sample_count); end
    for (int n = 0; n < FRAME_LEN; n++) begin
      rd(8'(n));
      n_cmp++; if (data_o !== 12'(n)) begin n_err++; $display("FAIL imm_read[%0d]: got %h want %h", n, data_o, 12'(n)); end
    end
    rd_addr = 8'd7;
    cyc();
    n_cmp++; if (data_o !== 12'h0FF) begin n_err++; $display("FAIL imm_rd_hold: got %h want 0ff", data_o); end
  endtask

  task automatic test_conversion();
    logic [11:0] raw [4];
    logic [11:0] exp [4];
    raw = '{12'h000, 12'hFFF, 12'h800, 12'h7FF};
    exp = '{12'h800, 12'h7FF, 12'h000, 12'hFFF};
    do_arm(1'b0);
    n_cmp++; if (done !== 1'b0 || sample_count !== 9'd0) begin n_err++; $display("FAIL conv_rearm: got done=%b count=%0d want 0/0", done, sample_count); end
    for (int i = 0; i < 4; i++) begin
      data_valid = 1'b1;
      data_i     = raw[i];
      cyc();
    end
    data_valid = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_cmp++; if (sample_count !== 9'd4 || busy !== 1'b0) begin n_err++; $display("FAIL conv_count: got count=%0d busy=%b want 4/0", sample_count, busy); end
    for (int i = 0; i < 4; i++) begin
      rd(8'(i));
      n_cmp++; if (data_o !== exp[i]) begin n_err++; $display("FAIL conv_read[%0d]: got %h want %h", i, data_o, exp[i]); end
    end
  endtask

  task automatic test_trigger();
    do_arm(1'b1);
    for (int i = 0; i < 20; i++) begin
      data_valid = 1'b1;
      data_i     = 12'h123;
      cyc();
    end
    n_cmp++; if (sample_count !== 9'd0 || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL trig_wait: got count=%0d busy=%b done=%b want 0/1/0", sample_count, busy, done); end
    trig   = 1'b1;
    data_i = 12'hABC;
    cyc();
    trig = 1'b0;
    n_cmp++; if (sample_count !== 9'd0 || busy !== 1'b1) begin n_err++; $display("FAIL trig_cycle: got count=%0d busy=%b want 0/1", sample_count, busy); end
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      data_valid = (i % 2 == 0);
      data_i     = (i % 2 == 0) ? 12'hC00 + 12'(i / 2) : 12'hFFF;
      cyc();
      if (i == 19) begin
        n_cmp++; if (sample_count !== 9'd10) begin n_err++; $display("FAIL trig_gaps: got %0d want 10", sample_count); end
      end
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || sample_count !== 9'd256) begin n_err++; $display("FAIL trig_done: got done=%b busy=%b count=%0d want 1/0/256", done, busy, sample_count); end
    data_valid = 1'b1;
    data_i     = 12'h000;
    repeat (3) cyc();
    data_valid = 1'b0;
    n_cmp++; if (sample_count !== 9'd256 || done !== 1'b1) begin n_err++; $display("FAIL trig_done_hold: got count=%0d done=%b want 256/1", sample_count, done); end
    rd(8'd0);
    n_cmp++; if (data_o !== 12'h400) begin n_err++; $display("FAIL trig_read0: got %h want 400", data_o); end
    rd(8'd100);
    n_cmp++; if (data_o !== 12'h464) begin n_err++; $display("FAIL trig_read100: got %h want 464", data_o); end
    rd(8'd255);
    n_cmp++; if (data_o !== 12'h4FF) begin n_err++; $display("FAIL trig_read255: got %h want 4ff", data_o); end
  endtask

  task automatic test_abort();
    do_arm(1'b0);
    feed(12'hA00, 50, 0);
    arm        = 1'b1;
    trig_mode  = 1'b1;
    data_valid = 1'b1;
    data_i     = 12'hA00 + 12'd50;
    cyc();
    arm = 1'b0;
    feed(12'hA00, 49, 51);
    n_cmp++; if (sample_count !== 9'd100 || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL abort_rearm_ignored: got count=%0d busy=%b done=%b want 100/1/0", sample_count, busy, done); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 9'd100) begin n_err++; $display("FAIL abort_idle: got busy=%b done=%b count=%0d want 0/0/100", busy, done, sample_count); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_cmp++; if (sample_count !== 9'd100 || busy !== 1'b0) begin n_err++; $display("FAIL abort_in_idle: got count=%0d busy=%b want 100/0", sample_count, busy); end
    do_arm(1'b0);
    feed(12'hA00, FRAME_LEN, 0);
    n_cmp++; if (done !== 1'b1 || sample_count !== 9'd256) begin n_err++; $display("FAIL abort_refill: got done=%b count=%0d want 1/256", done, sample_count); end
    rd(8'd150);
    n_cmp++; if (data_o !== 12'h296) begin n_err++; $display("FAIL abort_read150: got %h want 296", data_o); end
  endtask

  task automatic test_reset_mid();
    do_arm(1'b0);
    feed(12'h900, 50, 0);
    n_cmp++; if (sample_count !== 9'd50 || busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got count=%0d busy=%b want 50/1", sample_count, busy); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 9'd0 || data_o !== 12'h000) begin n_err++; $display("FAIL rstmid_async: got busy=%b done=%b count=%0d data=%h want 0/0/0/000", busy, done, sample_count, data_o); end
    cyc();
    cyc();
    reset = 1'b0;
    do_arm(1'b0);
    feed(12'h900, FRAME_LEN, 0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || sample_count !== 9'd256) begin n_err++; $display("FAIL rstmid_recapture: got done=%b busy=%b count=%0d want 1/0/256", done, busy, sample_count); end
    rd(8'd200);
    n_cmp++; if (data_o !== 12'h1C8) begin n_err++; $display("FAIL rstmid_read200: got %h want 1c8", data_o); end
  endtask

  task automatic test_back_to_back();
    do_arm(1'b0);
    feed(12'hB00, 10, 0);
    data_valid = 1'b1;
    data_i     = 12'hB00 + 12'd10;
    rd_en      = 1'b1;
    rd_addr    = 8'd10;
    cyc();
    n_cmp++; if (data_o !== 12'h10A) begin n_err++; $display("FAIL rdw_same_cycle: got %h want 10a", data_o); end
    data_i = 12'hB00 + 12'd11;
    cyc();
    rd_en = 1'b0;
    n_cmp++; if (data_o !== 12'h30A) begin n_err++; $display("FAIL rdw_next_cycle: got %h want 30a", data_o); end
    feed(12'hB00, 243, 12);
    n_cmp++; if (sample_count !== 9'd255 || busy !== 1'b1) begin n_err++; $display("FAIL rdw_pre_last: got count=%0d busy=%b want 255/1", sample_count, busy); end
    data_valid = 1'b1;
    data_i     = 12'hB00 + 12'd255;
    abort      = 1'b1;
    cyc();
    data_valid = 1'b0;
    abort      = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 9'd256) begin n_err++; $display("FAIL abort_final_write: got busy=%b done=%b count=%0d want 0/0/256", busy, done, sample_count); end
    rd(8'd255);
    n_cmp++; if (data_o !== 12'h3FF) begin n_err++; $display("FAIL abort_final_read: got %h want 3ff", data_o); end
  endtask

  initial begin
    reset      = 1'b1;
    arm        = 1'b0;
    trig_mode  = 1'b0;
    trig       = 1'b0;
    abort      = 1'b0;
    data_valid = 1'b0;
    data_i     = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    test_reset();
    test_immediate();
    test_conversion();
    test_trigger();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
